ysyx_23060077_ifu_prefetch: RTL and testbench

Parametrised prefetching instruction fetch unit. It replaces the single-entry IFU→IDU holding register with a FIFO of fetched {pc, inst} pairs. It streams sequential fetches to the I-cache while the IDU stalls and flushes everything on a redirect. It sits between the jump/redirect source (EXU), the Icache fetch port and the IDU handshake.

---
 rtl/ysyx_23060077_ifu_prefetch.sv | 187 ++++++++++++++++++
 tb/tb_ysyx_23060077_ifu_prefetch.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060077_ifu_prefetch.sv
// ysyx_23060077_ifu_prefetch
//   Prefetching instruction fetch unit. Sequential fetches to the I-cache are
//   queued as {pc, inst} pairs in a small FIFO so fetching continues while the
//   IDU stalls. A redirect flushes the FIFO and restarts fetch at the target.
//
// Ports:
//   clock, reset           system clock, synchronous active-high reset
//   jump_pc_valid/jump_pc  redirect pulse and target (bits [1:0] forced to 0)
//   icache_valid_o/addr_o  fetch request, held until icache_ready_i
//   icache_ready_i/data_i  fetch response pulse and instruction
//   if_to_id_valid_o       FIFO head valid
//   if_to_id_ready_i       IDU accepts head
//   ifu_pc_o/ifu_inst_o    FIFO head contents
//   fifo_count_o           current FIFO occupancy
//
// Optional build macro IFU_PF_PERF_EN adds perf_fetch_cnt_o and
// perf_drop_cnt_o (32-bit saturating push / discard counters).
module ysyx_23060077_ifu_prefetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h3000_0000,
    parameter int                    FIFO_DEPTH = 4,
    parameter int                    PC_STEP    = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          jump_pc_valid,
    input  logic [DATA_WIDTH-1:0]         jump_pc,
    output logic                          icache_valid_o,
    output logic [DATA_WIDTH-1:0]         icache_addr_o,
    input  logic                          icache_ready_i,
    input  logic [DATA_WIDTH-1:0]         icache_data_i,
    output logic                          if_to_id_valid_o,
    input  logic                          if_to_id_ready_i,
    output logic [DATA_WIDTH-1:0]         ifu_pc_o,
    output logic [DATA_WIDTH-1:0]         ifu_inst_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
`ifdef IFU_PF_PERF_EN
    ,
    output logic [31:0]                   perf_fetch_cnt_o,
    output logic [31:0]                   perf_drop_cnt_o
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]         DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] STEP_C  = DATA_WIDTH'(PC_STEP);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] fetch_pc_q;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] pc_inc;

    logic [DATA_WIDTH-1:0] mem_pc   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_inst [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]         count_q, count_next;

    logic fifo_valid;
    logic push;
    logic pop;
    logic issue_ok;
    logic discard;
    logic jump_lsb_unused;

    assign jump_lsb_unused = ^jump_pc[1:0];

    assign fifo_valid = (count_q != '0);
    // A redirect flushes the FIFO, so neither push nor pop take effect.
    assign pop        = fifo_valid & if_to_id_ready_i & ~jump_pc_valid;
    assign push       = (state_q == S_WAIT) & icache_ready_i & ~jump_pc_valid;
    assign count_next = count_q + CW'(push) - CW'(pop);
    // Only one request is ever in flight, so a free slot after this cycle's
    // push/pop is enough to guarantee room for its response.
    assign issue_ok   = (count_next < DEPTH_C);
    assign pc_inc     = fetch_pc_q + STEP_C;
    assign discard    = icache_ready_i &
                        ((state_q == S_DROP) | ((state_q == S_WAIT) & jump_pc_valid));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (!jump_pc_valid && issue_ok) begin
                    state_d = S_WAIT;
                    addr_d  = fetch_pc_q;
                end
            end
            S_WAIT: begin
                if (icache_ready_i) begin
                    if (jump_pc_valid) begin
                        state_d = S_IDLE;
                    end else if (issue_ok) begin
                        // Back-to-back: next sequential address goes out at once.
                        state_d = S_WAIT;
                        addr_d  = pc_inc;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (jump_pc_valid) begin
                    // Request already presented; hold the stale address until
                    // the cache answers, then throw the data away.
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (icache_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            if (jump_pc_valid) begin
                fetch_pc_q <= {jump_pc[DATA_WIDTH-1:2], 2'b00};
                rd_ptr_q   <= '0;
                wr_ptr_q   <= '0;
                count_q    <= '0;
            end else begin
                if (push) begin
                    fetch_pc_q <= pc_inc;
                    wr_ptr_q   <= wr_ptr_q + PW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PW'(1);
                end
                count_q <= count_next;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_pc[wr_ptr_q]   <= fetch_pc_q;
            mem_inst[wr_ptr_q] <= icache_data_i;
        end
    end

    assign icache_valid_o   = (state_q != S_IDLE);
    assign icache_addr_o    = addr_q;
    assign if_to_id_valid_o = fifo_valid;
    // Head is masked when empty so stale storage never shows on the outputs.
    assign ifu_pc_o         = fifo_valid ? mem_pc[rd_ptr_q]   : '0;
    assign ifu_inst_o       = fifo_valid ? mem_inst[rd_ptr_q] : '0;
    assign fifo_count_o     = count_q;

`ifdef IFU_PF_PERF_EN
    logic [31:0] perf_fetch_q, perf_drop_q;
    logic [31:0] drop_inc;
    logic [32:0] fetch_sum, drop_sum;

    assign drop_inc  = (jump_pc_valid ? 32'(count_q) : 32'd0) + 32'(discard);
    assign fetch_sum = {1'b0, perf_fetch_q} + 33'(push);
    assign drop_sum  = {1'b0, perf_drop_q} + {1'b0, drop_inc};

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            perf_fetch_q <= fetch_sum[32] ? '1 : fetch_sum[31:0];
            perf_drop_q  <= drop_sum[32]  ? '1 : drop_sum[31:0];
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_q;
    assign perf_drop_cnt_o  = perf_drop_q;
`endif

endmodule

// File: tb/tb_ysyx_23060077_ifu_prefetch.sv
module tb_ysyx_23060077_ifu_prefetch;

    localparam int          D        = 4;
    localparam logic [31:0] RST_PC   = 32'h3000_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        jump_pc_valid;
    logic [31:0] jump_pc;
    logic        icache_valid_o;
    logic [31:0] icache_addr_o;
    logic        icache_ready_i;
    logic [31:0] icache_data_i;
    logic        if_to_id_valid_o;
    logic        if_to_id_ready_i;
    logic [31:0] ifu_pc_o;
    logic [31:0] ifu_inst_o;
    logic [2:0]  fifo_count_o;
`ifdef IFU_PF_PERF_EN
    logic [31:0] perf_fetch_cnt_o;
    logic [31:0] perf_drop_cnt_o;
`endif

    always #5 clock = ~clock;

    ysyx_23060077_ifu_prefetch #(
        .DATA_WIDTH(32),
        .RESET_PC  (32'h3000_0000),
        .FIFO_DEPTH(4),
        .PC_STEP   (4)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .jump_pc_valid   (jump_pc_valid),
        .jump_pc         (jump_pc),
        .icache_valid_o  (icache_valid_o),
        .icache_addr_o   (icache_addr_o),
        .icache_ready_i  (icache_ready_i),
        .icache_data_i   (icache_data_i),
        .if_to_id_valid_o(if_to_id_valid_o),
        .if_to_id_ready_i(if_to_id_ready_i),
        .ifu_pc_o        (ifu_pc_o),
        .ifu_inst_o      (ifu_inst_o),
        .fifo_count_o    (fifo_count_o)
`ifdef IFU_PF_PERF_EN
        ,
        .perf_fetch_cnt_o(perf_fetch_cnt_o),
        .perf_drop_cnt_o (perf_drop_cnt_o)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    // Reference model: transaction-level view of the fetch stream.
    ent_t        q[$];      // instructions fetched but not yet taken by the IDU
    bit          m_out;     // a request is outstanding at the cache
    bit          m_stale;   // outstanding request belongs to a pre-redirect path
    logic [31:0] m_req;     // address of the outstanding request
    logic [31:0] m_fpc;     // next sequential fetch address
    int          m_wait;    // cycles the outstanding request has waited
    logic [31:0] m_pfetch;
    logic [31:0] m_pdrop;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("icache_valid", 32'(icache_valid_o), 32'(m_out));
        if (m_out) chk("icache_addr", icache_addr_o, m_req);
        chk("idu_valid", 32'(if_to_id_valid_o), 32'(q.size() > 0));
        chk("fifo_count", 32'(fifo_count_o), 32'(q.size()));
        if (q.size() > 0) begin
            chk("head_pc", ifu_pc_o, q[0].pc);
            chk("head_inst", ifu_inst_o, q[0].inst);
        end
`ifdef IFU_PF_PERF_EN
        chk("perf_fetch", perf_fetch_cnt_o, m_pfetch);
        chk("perf_drop", perf_drop_cnt_o, m_pdrop);
`endif
    endtask

    task automatic model_edge(input bit jr, input logic [31:0] jpc, input bit rdy,
                              input bit idr, input logic [31:0] data);
        int sz0;
        bit pop, push, disc;
        sz0  = q.size();
        pop  = (sz0 > 0) && idr && !jr;
        push = rdy && !m_stale && !jr;
        disc = rdy && (m_stale || jr);
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back('{pc: m_req, inst: data});
            m_fpc = m_fpc + 32'd4;
            m_pfetch = m_pfetch + 32'd1;
        end
        if (jr) begin
            m_pdrop = m_pdrop + 32'(sz0) + 32'(disc);
            q.delete();
            m_fpc = {jpc[31:2], 2'b00};
        end else if (disc) begin
            m_pdrop = m_pdrop + 32'd1;
        end
        if (m_out && !rdy) begin
            m_stale = m_stale || jr;
            m_wait++;
        end else if (m_out && rdy && m_stale) begin
            m_out   = 1'b0;
            m_stale = 1'b0;
        end else if (!jr && q.size() < D) begin
            m_out  = 1'b1;
            m_req  = m_fpc;
            m_wait = 0;
        end else begin
            m_out = 1'b0;
        end
    endtask

    // One clock: check current outputs, apply inputs, advance model and DUT.
    task automatic step(input bit jr, input logic [31:0] jpc, input bit rdy_req, input bit idr);
        bit rdy;
        check_outputs();
        rdy = rdy_req && m_out;
        jump_pc_valid    = jr;
        jump_pc          = jpc;
        icache_ready_i   = rdy;
        if_to_id_ready_i = idr;
        icache_data_i    = $urandom;
        model_edge(jr, jpc, rdy, idr, icache_data_i);
        @(posedge clock);
        #1;
        jump_pc_valid  = 1'b0;
        icache_ready_i = 1'b0;
    endtask

    // Cache answers once a request has waited 'lat' cycles.
    task automatic lat_step(input int lat, input bit idr);
        step(1'b0, 32'h0, (m_wait >= lat), idr);
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        jump_pc_valid    = 1'b0;
        jump_pc          = '0;
        icache_ready_i   = 1'b0;
        icache_data_i    = '0;
        if_to_id_ready_i = 1'b0;
        @(posedge clock);
        #1;
        q.delete();
        m_out    = 1'b0;
        m_stale  = 1'b0;
        m_req    = '0;
        m_fpc    = RST_PC;
        m_wait   = 0;
        m_pfetch = '0;
        m_pdrop  = '0;
        chk("reset_icache_valid", 32'(icache_valid_o), 32'd0);
        chk("reset_idu_valid", 32'(if_to_id_valid_o), 32'd0);
        chk("reset_pc", ifu_pc_o, 32'd0);
        chk("reset_inst", ifu_inst_o, 32'd0);
        chk("reset_count", 32'(fifo_count_o), 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        // Sequential stream, cache answers one cycle after valid, IDU always ready.
        do_reset();
        lat_step(1, 1'b1);
        chk("first_addr", icache_addr_o, 32'h3000_0000);
        lat_step(1, 1'b1);
        chk("no_head_before_resp", 32'(if_to_id_valid_o), 32'd0);
        lat_step(1, 1'b1);
        chk("first_head_valid", 32'(if_to_id_valid_o), 32'd1);
        chk("first_head_pc", ifu_pc_o, 32'h3000_0000);
        for (int i = 0; i < 12; i++) lat_step(1, 1'b1);

        // IDU stalled: FIFO fills to depth and fetching stops.
        do_reset();
        for (int i = 0; i < 20; i++) lat_step(0, 1'b0);
        chk("full_count", 32'(fifo_count_o), 32'd4);
        chk("full_icache_idle", 32'(icache_valid_o), 32'd0);
        chk("full_head_pc", ifu_pc_o, 32'h3000_0000);
        for (int i = 0; i < 4; i++) lat_step(100, 1'b1);
        chk("drained_count", 32'(fifo_count_o), 32'd0);
        chk("resume_addr", icache_addr_o, 32'h3000_0010);

        // Redirect while waiting: flush, hold stale address, discard its data.
        lat_step(0, 1'b0);
        lat_step(0, 1'b0);
        chk("prefill_count", 32'(fifo_count_o), 32'd2);
        step(1'b1, 32'h8000_0102, 1'b0, 1'b0);
        chk("flush_count", 32'(fifo_count_o), 32'd0);
        chk("flush_idu_valid", 32'(if_to_id_valid_o), 32'd0);
        chk("drop_valid", 32'(icache_valid_o), 32'd1);
        chk("drop_addr", icache_addr_o, 32'h3000_0018);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("drop_no_push", 32'(fifo_count_o), 32'd0);
        lat_step(5, 1'b1);
        chk("jump_addr", icache_addr_o, 32'h8000_0100);

        // Redirect coinciding with a response: no push, no drop phase.
        lat_step(0, 1'b0);
        step(1'b1, 32'h8000_0102, 1'b1, 1'b0);
        chk("jr_rdy_idle", 32'(icache_valid_o), 32'd0);
        chk("jr_rdy_count", 32'(fifo_count_o), 32'd0);
        lat_step(5, 1'b0);
        chk("jr_rdy_addr", icache_addr_o, 32'h8000_0100);

        // Push and pop in the same cycle at DEPTH-1, then pointer wrap.
        do_reset();
        for (int i = 0; i < 4; i++) lat_step(0, 1'b0);
        chk("almost_full", 32'(fifo_count_o), 32'd3);
        step(1'b0, 32'h0, 1'b1, 1'b1);
        chk("pushpop_count", 32'(fifo_count_o), 32'd3);
        chk("pushpop_fetching", 32'(icache_valid_o), 32'd1);
        for (int i = 0; i < 3 * D * 2; i++) lat_step(0, 1'b1);

        // Randomised traffic: variable latency, IDU back-pressure, redirects.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) < 3), $urandom,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) < 7));
        end

        // Reset during an outstanding request.
        for (int i = 0; i < 10 && !m_out; i++) lat_step(100, 1'b0);
        chk("pre_reset_wait", 32'(icache_valid_o), 32'd1);
        do_reset();
        lat_step(100, 1'b1);
        chk("post_reset_addr", icache_addr_o, RST_PC);
        for (int i = 0; i < 8; i++) lat_step(1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
